// File: rtl/mux_rr_scheduler.sv
// rtl/mux_rr_scheduler.sv - round-robin scheduler owning the select of a 16:1 bit mux
// Streams the granted channel's bit downstream in bursts of up to BURST accepted beats.
module mux_rr_scheduler #(
   parameter int N     = 16,
   parameter int SEL_W = 4,
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     data_in,
   input  logic             out_ready,
   output logic [SEL_W-1:0] sel,
   output logic [N-1:0]     grant,
   output logic             out_valid,
   output logic             out_data,
   output logic             busy
);

   localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_data_q, out_data_d;

   logic [SEL_W-1:0] scan_start;
   logic [SEL_W-1:0] scan_idx;
   logic [SEL_W-1:0] pick;
   logic             pick_vld;
   logic             last_beat;

   // While sending, the scan starts just past the current owner so it only wins again when alone.
   always_comb begin
      scan_start = (state_q == S_SEND) ? sel_q + SEL_W'(1) : ptr_q;
      scan_idx   = '0;
      pick       = '0;
      pick_vld   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         scan_idx = scan_start + SEL_W'(i);
         if (req[scan_idx]) begin
            pick     = scan_idx;
            pick_vld = 1'b1;
         end
      end
   end

   assign last_beat = (beat_cnt_q == CNT_W'(BURST - 1)) || !req[sel_q];

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      ptr_d       = ptr_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               sel_d       = pick;
               out_data_d  = data_in[pick];
               out_valid_d = 1'b1;
               beat_cnt_d  = '0;
               state_d     = S_SEND;
            end
         end
         S_SEND: begin
            if (out_ready) begin
               if (!last_beat) begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
                  out_data_d = data_in[sel_q];
               end else begin
                  ptr_d = sel_q + SEL_W'(1);
                  if (pick_vld) begin
                     sel_d      = pick;
                     out_data_d = data_in[pick];
                     beat_cnt_d = '0;
                  end else begin
                     out_valid_d = 1'b0;
                     state_d     = S_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         ptr_q       <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         ptr_q       <= ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign sel       = sel_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q == S_SEND);
   assign grant     = busy ? ({{(N-1){1'b0}}, 1'b1} << sel_q) : '0;

endmodule
